alu_share_arbiter: RTL and testbench

//  Shares the single ALU (and its alu_control decode) between two requesters,
//  e.g. main execute path (r0) and address/branch unit (r1). Round-robin arbitration

---
 rtl/alu_share_arbiter_if.sv | 49 ++++
 rtl/alu_share_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, ALU and response signals shared by alu_share_arbiter.
// The slave modport is the arbiter; master is the requesters plus the ALU.
interface alu_share_arbiter_if #(
    parameter int unsigned DATA_W = 16
);
    logic              r0_valid;
    logic              r0_ready;
    logic [1:0]        r0_aluop;
    logic [5:0]        r0_opcode;
    logic [DATA_W-1:0] r0_a;
    logic [DATA_W-1:0] r0_b;

    logic              r1_valid;
    logic              r1_ready;
    logic [1:0]        r1_aluop;
    logic [5:0]        r1_opcode;
    logic [DATA_W-1:0] r1_a;
    logic [DATA_W-1:0] r1_b;

    logic [1:0]        alu_aluop;
    logic [5:0]        alu_opcode;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_start;
    logic [DATA_W-1:0] alu_result;

    logic [DATA_W-1:0] rsp_data;
    logic              r0_rsp_valid;
    logic              r1_rsp_valid;
    logic              busy;

    modport slave (
        input  r0_valid, r0_aluop, r0_opcode, r0_a, r0_b,
        input  r1_valid, r1_aluop, r1_opcode, r1_a, r1_b,
        input  alu_result,
        output r0_ready, r1_ready,
        output alu_aluop, alu_opcode, alu_a, alu_b, alu_start,
        output rsp_data, r0_rsp_valid, r1_rsp_valid, busy
    );

    modport master (
        output r0_valid, r0_aluop, r0_opcode, r0_a, r0_b,
        output r1_valid, r1_aluop, r1_opcode, r1_a, r1_b,
        output alu_result,
        input  r0_ready, r1_ready,
        input  alu_aluop, alu_opcode, alu_a, alu_b, alu_start,
        input  rsp_data, r0_rsp_valid, r1_rsp_valid, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters.
// One operation in flight: IDLE accepts, EXEC waits ALU_LAT cycles, DONE responds.
module alu_share_arbiter #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ALU_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_grant_q, last_grant_d;
    logic [1:0]          aluop_q, aluop_d;
    logic [5:0]          opcode_q, opcode_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                alu_start_q, alu_start_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                r0_rsp_valid_q, r0_rsp_valid_d;
    logic                r1_rsp_valid_q, r1_rsp_valid_d;
    logic                busy_q, busy_d;

    logic                grant_r0_c, grant_r1_c, xfer_c;

    // r1 wins when it is the only requester or when r0 was served last
    always_comb begin
        grant_r1_c = bus.r1_valid && (!bus.r0_valid || !last_grant_q);
        grant_r0_c = bus.r0_valid && !grant_r1_c;
        xfer_c     = rst_n && (state_q == IDLE) && (grant_r0_c || grant_r1_c);
    end

    assign bus.r0_ready = rst_n && (state_q == IDLE) && grant_r0_c;
    assign bus.r1_ready = rst_n && (state_q == IDLE) && grant_r1_c;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        last_grant_d   = last_grant_q;
        aluop_d        = aluop_q;
        opcode_d       = opcode_q;
        a_d            = a_q;
        b_d            = b_q;
        alu_start_d    = 1'b0;
        rsp_data_d     = rsp_data_q;
        r0_rsp_valid_d = 1'b0;
        r1_rsp_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer_c) begin
                    if (grant_r1_c) begin
                        aluop_d  = bus.r1_aluop;
                        opcode_d = bus.r1_opcode;
                        a_d      = bus.r1_a;
                        b_d      = bus.r1_b;
                    end else begin
                        aluop_d  = bus.r0_aluop;
                        opcode_d = bus.r0_opcode;
                        a_d      = bus.r0_a;
                        b_d      = bus.r0_b;
                    end
                    last_grant_d = grant_r1_c;
                    cnt_d        = CNT_W'(ALU_LAT);
                    alu_start_d  = 1'b1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Last EXEC cycle: result is valid now, tag the response for DONE
                if (cnt_q == CNT_W'(1)) begin
                    rsp_data_d     = bus.alu_result;
                    r0_rsp_valid_d = !last_grant_q;
                    r1_rsp_valid_d = last_grant_q;
                    state_d        = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            last_grant_q   <= 1'b1;
            aluop_q        <= '0;
            opcode_q       <= '0;
            a_q            <= '0;
            b_q            <= '0;
            alu_start_q    <= 1'b0;
            rsp_data_q     <= '0;
            r0_rsp_valid_q <= 1'b0;
            r1_rsp_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_grant_q   <= last_grant_d;
            aluop_q        <= aluop_d;
            opcode_q       <= opcode_d;
            a_q            <= a_d;
            b_q            <= b_d;
            alu_start_q    <= alu_start_d;
            rsp_data_q     <= rsp_data_d;
            r0_rsp_valid_q <= r0_rsp_valid_d;
            r1_rsp_valid_q <= r1_rsp_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.alu_aluop    = aluop_q;
    assign bus.alu_opcode   = opcode_q;
    assign bus.alu_a        = a_q;
    assign bus.alu_b        = b_q;
    assign bus.alu_start    = alu_start_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.r0_rsp_valid = r0_rsp_valid_q;
    assign bus.r1_rsp_valid = r1_rsp_valid_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: ALU_LAT=2 main instance plus ALU_LAT=1/4 builds.
// The ALU model returns a+b only in the cycle ALU_LAT-1 after alu_start, 16'hDEAD otherwise.
module tb_alu_share_arbiter;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.DATA_W(DW)) if2 ();
    alu_share_arbiter_if #(.DATA_W(DW)) if1 ();
    alu_share_arbiter_if #(.DATA_W(DW)) if4 ();

    alu_share_arbiter #(.DATA_W(DW), .ALU_LAT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    alu_share_arbiter #(.DATA_W(DW), .ALU_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    alu_share_arbiter #(.DATA_W(DW), .ALU_LAT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    // ALU models: age counts cycles since alu_start (0 in the start cycle)
    logic [3:0] age2_q, age1_q, age4_q;
    logic [3:0] age2, age1, age4;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age2_q <= 4'd0; age1_q <= 4'd0; age4_q <= 4'd0;
        end else begin
            if (if2.alu_start) age2_q <= 4'd1;
            else if (age2_q != 4'd0 && age2_q != 4'd15) age2_q <= age2_q + 4'd1;
            if (if1.alu_start) age1_q <= 4'd1;
            else if (age1_q != 4'd0 && age1_q != 4'd15) age1_q <= age1_q + 4'd1;
            if (if4.alu_start) age4_q <= 4'd1;
            else if (age4_q != 4'd0 && age4_q != 4'd15) age4_q <= age4_q + 4'd1;
        end
    end

    assign age2 = if2.alu_start ? 4'd0 : ((age2_q == 4'd0) ? 4'd15 : age2_q);
    assign age1 = if1.alu_start ? 4'd0 : ((age1_q == 4'd0) ? 4'd15 : age1_q);
    assign age4 = if4.alu_start ? 4'd0 : ((age4_q == 4'd0) ? 4'd15 : age4_q);

    assign if2.alu_result = (age2 == 4'd1) ? 16'(if2.alu_a + if2.alu_b) : 16'hDEAD;
    assign if1.alu_result = (age1 == 4'd0) ? 16'(if1.alu_a + if1.alu_b) : 16'hDEAD;
    assign if4.alu_result = (age4 == 4'd3) ? 16'(if4.alu_a + if4.alu_b) : 16'hDEAD;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_r0(input logic v, input logic [1:0] op, input logic [5:0] opc,
                          input logic [15:0] a, input logic [15:0] b);
        if2.r0_valid = v; if2.r0_aluop = op; if2.r0_opcode = opc; if2.r0_a = a; if2.r0_b = b;
    endtask

    task automatic set_r1(input logic v, input logic [1:0] op, input logic [5:0] opc,
                          input logic [15:0] a, input logic [15:0] b);
        if2.r1_valid = v; if2.r1_aluop = op; if2.r1_opcode = opc; if2.r1_a = a; if2.r1_b = b;
    endtask

    // Structural invariants on the main instance, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("ready_onehot", {31'd0, if2.r0_ready & if2.r1_ready}, 32'd0);
            chk("rsp_exclusive", {31'd0, if2.r0_rsp_valid & if2.r1_rsp_valid}, 32'd0);
        end
    end

    int          i0, i1, g;
    logic [15:0] exp_a, exp_b;
    logic [1:0]  exp_op;
    logic [5:0]  exp_opc;

    initial begin
        rst_n = 1'b0;
        set_r0(1'b0, 2'd0, 6'd0, 16'd0, 16'd0);
        set_r1(1'b0, 2'd0, 6'd0, 16'd0, 16'd0);
        if1.r0_valid = 1'b0; if1.r0_aluop = 2'd0; if1.r0_opcode = 6'd0; if1.r0_a = 16'd0; if1.r0_b = 16'd0;
        if1.r1_valid = 1'b0; if1.r1_aluop = 2'd0; if1.r1_opcode = 6'd0; if1.r1_a = 16'd0; if1.r1_b = 16'd0;
        if4.r0_valid = 1'b0; if4.r0_aluop = 2'd0; if4.r0_opcode = 6'd0; if4.r0_a = 16'd0; if4.r0_b = 16'd0;
        if4.r1_valid = 1'b0; if4.r1_aluop = 2'd0; if4.r1_opcode = 6'd0; if4.r1_a = 16'd0; if4.r1_b = 16'd0;

        // Reset state, with r0 already requesting
        set_r0(1'b1, 2'b00, 6'h04, 16'd5, 16'd3);
        #12;
        chk("rst_r0_ready", if2.r0_ready, 0);
        chk("rst_r1_ready", if2.r1_ready, 0);
        chk("rst_alu_start", if2.alu_start, 0);
        chk("rst_alu_a", if2.alu_a, 0);
        chk("rst_busy", if2.busy, 0);
        chk("rst_rsp_data", if2.rsp_data, 0);
        chk("rst_r0_rsp_valid", if2.r0_rsp_valid, 0);

        // Test 1: single r0 op 5+3
        @(negedge clk); rst_n = 1'b1; #1;
        chk("t1_r0_ready_T", if2.r0_ready, 1);
        chk("t1_r1_ready_T", if2.r1_ready, 0);
        chk("t1_busy_T", if2.busy, 0);
        cyc();
        if2.r0_valid = 1'b0;
        chk("t1_alu_start_T1", if2.alu_start, 1);
        chk("t1_alu_opcode", if2.alu_opcode, 32'h04);
        chk("t1_alu_aluop", if2.alu_aluop, 0);
        chk("t1_alu_a", if2.alu_a, 5);
        chk("t1_alu_b", if2.alu_b, 3);
        chk("t1_busy_T1", if2.busy, 1);
        cyc();
        chk("t1_alu_start_T2", if2.alu_start, 0);
        chk("t1_alu_a_T2", if2.alu_a, 5);
        chk("t1_rsp_valid_T2", if2.r0_rsp_valid, 0);
        cyc();
        chk("t1_r0_rsp_valid_T3", if2.r0_rsp_valid, 1);
        chk("t1_r1_rsp_valid_T3", if2.r1_rsp_valid, 0);
        chk("t1_rsp_data_T3", if2.rsp_data, 8);
        chk("t1_busy_T3", if2.busy, 1);
        cyc();
        chk("t1_r0_rsp_valid_T4", if2.r0_rsp_valid, 0);
        chk("t1_busy_T4", if2.busy, 0);
        chk("t1_rsp_data_held", if2.rsp_data, 8);
        chk("t1_alu_a_held", if2.alu_a, 5);

        // Test 2: both valid continuously after a fresh reset, 4 ops each
        rst_n = 1'b0;
        i0 = 0; i1 = 0;
        set_r0(1'b1, 2'b00, 6'h20, 16'h0010, 16'h0000);
        set_r1(1'b1, 2'b10, 6'h22, 16'h1000, 16'h0003);
        @(negedge clk); rst_n = 1'b1; #1;
        for (int k = 0; k < 8; k++) begin
            g = k % 2;
            chk("t2_r0_ready", if2.r0_ready, 32'(g == 0));
            chk("t2_r1_ready", if2.r1_ready, 32'(g == 1));
            if (g == 0) begin
                exp_a = 16'(16'h0010 + i0); exp_b = 16'(16'h0100 * i0); exp_op = 2'b00; exp_opc = 6'(6'h20 + i0);
            end else begin
                exp_a = 16'(16'h1000 + i1); exp_b = 16'h0003; exp_op = 2'b10; exp_opc = 6'h22;
            end
            cyc();
            chk("t2_alu_start", if2.alu_start, 1);
            chk("t2_alu_a", if2.alu_a, 32'(exp_a));
            chk("t2_alu_b", if2.alu_b, 32'(exp_b));
            chk("t2_alu_aluop", if2.alu_aluop, 32'(exp_op));
            chk("t2_alu_opcode", if2.alu_opcode, 32'(exp_opc));
            if (g == 0) begin
                i0++;
                if (i0 == 4) if2.r0_valid = 1'b0;
                else set_r0(1'b1, 2'b00, 6'(6'h20 + i0), 16'(16'h0010 + i0), 16'(16'h0100 * i0));
            end else begin
                i1++;
                if (i1 == 4) if2.r1_valid = 1'b0;
                else set_r1(1'b1, 2'b10, 6'h22, 16'(16'h1000 + i1), 16'h0003);
            end
            cyc(); cyc();
            chk("t2_r0_rsp_valid", if2.r0_rsp_valid, 32'(g == 0));
            chk("t2_r1_rsp_valid", if2.r1_rsp_valid, 32'(g == 1));
            chk("t2_rsp_data", if2.rsp_data, 32'(16'(exp_a + exp_b)));
            cyc();
        end

        // Test 3: only r1 valid for 3 ops, then a tie goes to r0
        set_r1(1'b1, 2'b01, 6'h2A, 16'h0200, 16'h0022);
        #1;
        for (int j = 0; j < 3; j++) begin
            chk("t3_r1_ready", if2.r1_ready, 1);
            chk("t3_r0_ready", if2.r0_ready, 0);
            cyc();
            chk("t3_alu_a", if2.alu_a, 32'(16'h0200 + j));
            if (j == 2) if2.r1_valid = 1'b0;
            else set_r1(1'b1, 2'b01, 6'h2A, 16'(16'h0200 + j + 1), 16'h0022);
            cyc(); cyc();
            chk("t3_r1_rsp_valid", if2.r1_rsp_valid, 1);
            chk("t3_r0_rsp_valid", if2.r0_rsp_valid, 0);
            chk("t3_rsp_data", if2.rsp_data, 32'(16'h0222 + j));
            cyc();
        end
        set_r0(1'b1, 2'b00, 6'h01, 16'd1, 16'd2);
        set_r1(1'b1, 2'b01, 6'h2A, 16'h0300, 16'h0001);
        #1;
        chk("t3_tie_r0_ready", if2.r0_ready, 1);
        chk("t3_tie_r1_ready", if2.r1_ready, 0);
        cyc();
        if2.r0_valid = 1'b0; if2.r1_valid = 1'b0;
        chk("t3_tie_alu_a", if2.alu_a, 1);
        cyc(); cyc();
        chk("t3_tie_r0_rsp_valid", if2.r0_rsp_valid, 1);
        chk("t3_tie_rsp_data", if2.rsp_data, 3);
        cyc();

        // Test 4: reset in the middle of EXEC
        set_r0(1'b1, 2'b11, 6'h3F, 16'd7, 16'd9);
        #1;
        chk("t4_r0_ready", if2.r0_ready, 1);
        cyc();
        if2.r0_valid = 1'b0;
        chk("t4_busy_T1", if2.busy, 1);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("t4_rst_alu_a", if2.alu_a, 0);
        chk("t4_rst_alu_opcode", if2.alu_opcode, 0);
        chk("t4_rst_alu_aluop", if2.alu_aluop, 0);
        chk("t4_rst_busy", if2.busy, 0);
        chk("t4_rst_rsp_data", if2.rsp_data, 0);
        @(negedge clk); rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            cyc();
            chk("t4_no_r0_rsp", if2.r0_rsp_valid, 0);
            chk("t4_no_r1_rsp", if2.r1_rsp_valid, 0);
            chk("t4_idle_busy", if2.busy, 0);
        end
        set_r0(1'b1, 2'b00, 6'h04, 16'd4, 16'd4);
        set_r1(1'b1, 2'b01, 6'h05, 16'd9, 16'd9);
        #1;
        chk("t4_tie_r0_ready", if2.r0_ready, 1);
        chk("t4_tie_r1_ready", if2.r1_ready, 0);
        cyc();
        if2.r0_valid = 1'b0; if2.r1_valid = 1'b0;
        cyc(); cyc();
        chk("t4_r0_rsp_valid", if2.r0_rsp_valid, 1);
        chk("t4_rsp_data", if2.rsp_data, 8);
        cyc();

        // Test 6: r0 pulses valid while busy and must never be accepted
        set_r1(1'b1, 2'b10, 6'h11, 16'h0050, 16'h0005);
        #1;
        chk("t6_r1_ready", if2.r1_ready, 1);
        cyc();
        if2.r1_valid = 1'b0;
        cyc();
        set_r0(1'b1, 2'b11, 6'h3C, 16'hAAAA, 16'h1111);
        #1;
        chk("t6_r0_ready_busy", if2.r0_ready, 0);
        cyc();
        if2.r0_valid = 1'b0;
        chk("t6_r1_rsp_valid", if2.r1_rsp_valid, 1);
        chk("t6_r0_rsp_valid", if2.r0_rsp_valid, 0);
        chk("t6_rsp_data", if2.rsp_data, 32'h0055);
        for (int j = 0; j < 4; j++) begin
            cyc();
            chk("t6_no_r0_rsp", if2.r0_rsp_valid, 0);
            chk("t6_no_busy", if2.busy, 0);
            chk("t6_alu_a_kept", if2.alu_a, 32'h0050);
        end

        // Test 5: ALU_LAT=1 and ALU_LAT=4 timing
        if1.r0_valid = 1'b1; if1.r0_opcode = 6'h09; if1.r0_a = 16'd20; if1.r0_b = 16'd22;
        if4.r0_valid = 1'b1; if4.r0_opcode = 6'h09; if4.r0_a = 16'd20; if4.r0_b = 16'd22;
        #1;
        chk("t5_l1_ready", if1.r0_ready, 1);
        chk("t5_l4_ready", if4.r0_ready, 1);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            if (k == 1) begin
                if1.r0_valid = 1'b0; if4.r0_valid = 1'b0;
            end
            chk("t5_l1_start", if1.alu_start, 32'(k == 1));
            chk("t5_l1_busy", if1.busy, 32'(k <= 2));
            chk("t5_l1_rsp_valid", if1.r0_rsp_valid, 32'(k == 2));
            chk("t5_l1_alu_a", if1.alu_a, 20);
            chk("t5_l4_start", if4.alu_start, 32'(k == 1));
            chk("t5_l4_busy", if4.busy, 32'(k <= 5));
            chk("t5_l4_rsp_valid", if4.r0_rsp_valid, 32'(k == 5));
            chk("t5_l4_alu_b", if4.alu_b, 22);
            if (k == 2) chk("t5_l1_rsp_data", if1.rsp_data, 42);
            if (k == 5) chk("t5_l4_rsp_data", if4.rsp_data, 42);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
